// File: rtl/packet_scheduler.sv
// packet_scheduler: arms on request, starts on a sync rising edge, gates whole packets to the MAC and stops on packet boundaries.
module packet_scheduler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             disarm,
    input  logic [CNT_W-1:0] num_packets,
    input  logic             sync_in,
    output logic             pkt_ce,
    output logic             pkt_rst,
    output logic             pkt_sync,
    input  logic [63:0]      tx_data_in,
    input  logic             tx_valid_in,
    input  logic             tx_eod_in,
    input  logic             tx_afull,
    output logic [63:0]      tx_data,
    output logic             tx_valid,
    output logic             tx_eod,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] packet_count,
    output logic [CNT_W-1:0] dropped_count,
    output logic             done
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    state_t st, nxt;
    logic sync_q, in_pkt, pass_q, stop_req;
    logic [CNT_W-1:0] limit, pc_inc;
    logic sop, pass_sop, pass_n, fwd, fwd_eod, in_pkt_n, sync_rise, start, afull_drop, limit_hit;
    assign state = st;
    always_comb begin
        sop        = tx_valid_in & ~in_pkt;
        pass_sop   = (st == RUN) & ~tx_afull & ~stop_req;
        pass_n     = sop ? pass_sop : pass_q;
        fwd        = tx_valid_in & pass_n;
        fwd_eod    = fwd & tx_eod_in;
        in_pkt_n   = sop ? ~tx_eod_in : in_pkt & ~(tx_valid_in & tx_eod_in);
        sync_rise  = sync_in & ~sync_q;
        start      = arm & ~disarm;
        afull_drop = sop & (st == RUN) & ~stop_req & tx_afull;
        pc_inc     = packet_count + 1'b1;
        limit_hit  = fwd_eod & (limit != '0) & (pc_inc == limit);
        nxt        = st;
        unique case (st)
            IDLE:    nxt = start ? ARMED : IDLE;
            ARMED:   nxt = disarm ? IDLE : (sync_rise ? RUN : ARMED);
            // a stop waits only while a forwarded packet is still open after this beat
            RUN:     nxt = limit_hit ? DONE : (((stop_req | disarm) & ~(in_pkt_n & pass_n)) ? IDLE : RUN);
            DONE:    nxt = disarm ? IDLE : (arm ? ARMED : DONE);
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            sync_q        <= 1'b0;
            in_pkt        <= 1'b0;
            pass_q        <= 1'b0;
            stop_req      <= 1'b0;
            limit         <= '0;
            pkt_ce        <= 1'b0;
            pkt_rst       <= 1'b1;
            pkt_sync      <= 1'b0;
            done          <= 1'b0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            tx_eod        <= 1'b0;
            packet_count  <= '0;
            dropped_count <= '0;
        end else begin
            st       <= nxt;
            sync_q   <= sync_in;
            in_pkt   <= in_pkt_n;
            pass_q   <= pass_n;
            stop_req <= (nxt == RUN) & (stop_req | ((st == RUN) & disarm));
            pkt_ce   <= nxt == RUN;
            pkt_rst  <= (nxt == IDLE) | (nxt == DONE);
            done     <= nxt == DONE;
            pkt_sync <= (st == ARMED) & (nxt == RUN);
            tx_valid <= fwd;
            tx_eod   <= fwd_eod;
            tx_data  <= fwd ? tx_data_in : '0;
            if (((st == IDLE) | (st == DONE)) & (nxt == ARMED)) begin
                limit         <= num_packets;
                packet_count  <= '0;
                dropped_count <= '0;
            end else begin
                if (fwd_eod) packet_count <= pc_inc;
                if (afull_drop) dropped_count <= dropped_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: randomized packets checked by a scoreboard against a packet-level model of the scheduler.
module tb_packet_scheduler;
    logic        clk, rst_n, arm, disarm, sync_in;
    logic [31:0] num_packets;
    logic        pkt_ce, pkt_rst, pkt_sync;
    logic [63:0] tx_data_in, tx_data;
    logic        tx_valid_in, tx_eod_in, tx_afull, tx_valid, tx_eod, done;
    logic [1:0]  state;
    logic [31:0] packet_count, dropped_count;

    packet_scheduler #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .num_packets(num_packets),
        .sync_in(sync_in), .pkt_ce(pkt_ce), .pkt_rst(pkt_rst), .pkt_sync(pkt_sync),
        .tx_data_in(tx_data_in), .tx_valid_in(tx_valid_in), .tx_eod_in(tx_eod_in),
        .tx_afull(tx_afull), .tx_data(tx_data), .tx_valid(tx_valid), .tx_eod(tx_eod),
        .state(state), .packet_count(packet_count), .dropped_count(dropped_count), .done(done)
    );

    typedef struct {logic [63:0] d; logic e; int c;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int errors = 0, checks = 0, cyc = 0;
    int m_state = 0, m_count = 0, m_drop = 0, m_limit = 0;
    bit m_stop = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_status();
        chk("state", state, m_state);
        chk("packet_count", packet_count, m_count);
        chk("dropped_count", dropped_count, m_drop);
        chk("done", done, m_state == 3);
        chk("pkt_ce", pkt_ce, m_state == 2);
        chk("pkt_rst", pkt_rst, m_state == 0 || m_state == 3);
    endtask

    always @(negedge clk) begin
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %h, expected no beat", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tx_data", tx_data, mon_e.d);
                chk("tx_eod", tx_eod, mon_e.e);
                chk("latency_cycle", cyc, mon_e.c);
            end
        end else chk("idle_zero", tx_data | 64'(tx_eod), 0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input int n);
        num_packets = n;
        arm = 1;
        @(negedge clk);
        arm = 0;
        m_state = 1; m_count = 0; m_drop = 0; m_limit = n; m_stop = 0;
        chk_status();
        idle(4);
        sync_in = 1;
        @(negedge clk);
        m_state = 2;
        chk_status();
        chk("pkt_sync_pulse", pkt_sync, 1);
        @(negedge clk);
        chk("pkt_sync_end", pkt_sync, 0);
        sync_in = 0;
    endtask

    // Model: pass is decided per packet at its first beat; bookkeeping follows at its end.
    task automatic run_pkt(input int len, input bit af, input int dis_at);
        bit pass;
        pass = (m_state == 2) && !af && !m_stop;
        if (m_state == 2 && !m_stop && af) m_drop++;
        for (int i = 0; i < len; i++) begin
            tx_valid_in = 1;
            tx_data_in  = {$urandom, $urandom};
            tx_eod_in   = (i == len - 1);
            tx_afull    = (i == 0) ? af : 1'($urandom_range(0, 1));
            disarm      = (i == dis_at);
            if (pass) exp_q.push_back('{tx_data_in, tx_eod_in, cyc + 1});
            if (i == dis_at && m_state == 2) begin
                m_stop = 1;
                if (!pass) begin m_state = 0; m_stop = 0; end
            end
            @(negedge clk);
        end
        tx_valid_in = 0; tx_eod_in = 0; tx_afull = 0; disarm = 0; tx_data_in = 0;
        if (pass) begin
            m_count++;
            if (m_limit != 0 && m_count == m_limit) m_state = 3;
            else if (m_stop) m_state = 0;
            if (m_state != 2) m_stop = 0;
        end
    endtask

    task automatic do_disarm();
        disarm = 1;
        @(negedge clk);
        disarm = 0;
        m_state = 0;
        m_stop = 0;
    endtask

    initial begin
        rst_n = 0; arm = 0; disarm = 0; sync_in = 0; num_packets = 0;
        tx_data_in = 0; tx_valid_in = 0; tx_eod_in = 0; tx_afull = 0;
        idle(2);
        chk_status();
        chk("reset_pkt_sync", pkt_sync, 0);
        chk("reset_tx_valid", tx_valid, 0);
        rst_n = 1;
        idle(1);

        start_run(3);
        for (int p = 0; p < 3; p++) run_pkt(8, 0, -1);
        chk_status();

        start_run(0);
        run_pkt(8, 0, -1);
        run_pkt(8, 1, -1);
        run_pkt(8, 0, -1);
        chk_status();
        run_pkt(8, 0, 3);
        chk_status();
        run_pkt(8, 0, -1);
        chk_status();

        arm = 1; disarm = 1;
        @(negedge clk);
        arm = 0; disarm = 0;
        chk_status();
        arm = 1;
        @(negedge clk);
        arm = 0;
        m_state = 1; m_count = 0; m_drop = 0;
        chk_status();
        idle(2);
        sync_in = 1; disarm = 1;
        @(negedge clk);
        disarm = 0;
        m_state = 0;
        chk_status();
        chk("no_sync_on_disarm", pkt_sync, 0);
        sync_in = 0;
        idle(1);

        for (int r = 0; r < 4; r++) begin
            start_run($urandom_range(2, 5));
            for (int k = 0; k < 8 && m_state == 2; k++) begin
                int len, da;
                len = $urandom_range(1, 6);
                da = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
                run_pkt(len, $urandom_range(0, 3) == 0, da);
                idle($urandom_range(0, 2));
            end
            chk_status();
            if (m_state != 0) do_disarm();
            chk_status();
        end

        start_run(0);
        for (int i = 0; i < 3; i++) begin
            tx_valid_in = 1; tx_data_in = {$urandom, $urandom}; tx_eod_in = 0;
            exp_q.push_back('{tx_data_in, 1'b0, cyc + 1});
            @(negedge clk);
        end
        #2 rst_n = 0;
        #1;
        m_state = 0; m_count = 0; m_drop = 0; m_stop = 0;
        chk_status();
        chk("async_tx_valid", tx_valid, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_tx_eod", tx_eod, 0);
        tx_valid_in = 0; tx_data_in = 0;
        @(negedge clk);
        rst_n = 1;
        idle(1);
        start_run(0);
        run_pkt(1, 0, -1);
        chk_status();
        do_disarm();
        chk_status();

        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
